// File: rtl/i2s_pkg.sv
// Shared constants, channel encoding and slot helper for the I2S transmitter.
package i2s_pkg;

  localparam int DEF_SAMPLE_WIDTH = 24;
  localparam int DEF_SLOT_WIDTH   = 24;
  localparam int DEF_HALF_PERIOD  = 24;

  // Word-select level for each channel
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  // Number of zero bits sent after the sample LSB inside one slot
  function automatic int slot_pad(int sample_w, int slot_w);
    return slot_w - sample_w;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair valid/ready handshake between the audio source and the transmitter.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_WIDTH = i2s_pkg::DEF_SAMPLE_WIDTH
) ();

  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (
    output sample_left, sample_right, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left, sample_right, sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: prescaler on clk_ref, SCK register and edge strobes.
// The strobes are high in the cycle before SCK changes, so logic clocked on
// the same edge updates together with SCK.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clk_ref,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int            CW       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tc;

  // Prescaler advance and SCK toggle at terminal count; stopping clears both
  always_comb begin
    tc       = enable && (cnt_q == CNT_LAST);
    cnt_d    = '0;
    sck_d    = 1'b0;
    if (enable) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
      sck_d = tc ? ~sck_q : sck_q;
    end
    rise_evt = tc && !sck_q;
    fall_evt = tc && sck_q;
  end

  // Prescaler and SCK state
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter: one-deep holding register behind a valid/ready
// handshake, a frame-wide shifter and the frame position counter p.
// WS, SD and p all change on the clk_ref edge where SCK falls.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int HALF_PERIOD  = DEF_HALF_PERIOD
) (
  input  logic                clk_ref,
  input  logic                reset,
  input  logic                enable,
  i2s_tx_serializer_if.slave  smp,
  output logic                i2s_sck,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                frame_start,
  output logic                underrun
);

  localparam int            FW      = 2 * SLOT_WIDTH;
  localparam int            PW      = $clog2(FW);
  localparam int            PAD     = slot_pad(SAMPLE_WIDTH, SLOT_WIDTH);
  localparam logic [PW-1:0] P_LAST  = PW'(FW - 1);
  localparam logic [PW-1:0] P_RIGHT = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] P_LOAD  = PW'(1);

  logic                    fall_evt;
  logic                    rise_unused;

  logic [PW-1:0]           p_q, p_d;
  ch_e                     ws_q, ws_d;
  logic [FW-1:0]           sh_q, sh_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                    ready_q, ready_d;
  logic [SLOT_WIDTH-1:0]   slot_l, slot_r;
  logic                    accept, load;

  i2s_sck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sck_gen (
    .clk_ref  (clk_ref),
    .reset    (reset),
    .enable   (enable),
    .sck      (i2s_sck),
    .rise_evt (rise_unused),
    .fall_evt (fall_evt)
  );

  // Samples left-justified in their slots, zero padded below the LSB
  assign slot_l = SLOT_WIDTH'(hold_l_q) << PAD;
  assign slot_r = SLOT_WIDTH'(hold_r_q) << PAD;

  // Frame sequencing on falling SCK plus the holding-register handshake
  always_comb begin
    p_d         = p_q;
    ws_d        = ws_q;
    sh_d        = sh_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    load        = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    accept      = smp.sample_valid && ready_q;

    if (!enable) begin
      p_d  = P_LAST;
      ws_d = CH_LEFT;
      sh_d = '0;
    end else if (fall_evt) begin
      p_d  = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      ws_d = (p_d >= P_RIGHT) ? CH_RIGHT : CH_LEFT;
      // Entering p = 1 starts a frame: one bit of I2S delay after WS
      if (p_d == P_LOAD) begin
        load = 1'b1;
        fs_d = 1'b1;
        if (hold_full_q) begin
          sh_d = {slot_l, slot_r};
        end else begin
          sh_d = '0;
          ur_d = 1'b1;
        end
      end else begin
        sh_d = sh_q << 1;
      end
    end

    // ready is low whenever the holding register is full, so an accept
    // can never coincide with a load that drains it
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = smp.sample_left;
      hold_r_d    = smp.sample_right;
    end else if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    ready_d = !hold_full_d;
  end

  // Serializer state; reset aborts the frame and drops any held sample
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      p_q         <= P_LAST;
      ws_q        <= CH_LEFT;
      sh_q        <= '0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      ws_q        <= ws_d;
      sh_q        <= sh_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      ready_q     <= ready_d;
    end
  end

  assign i2s_ws           = ws_q;
  assign i2s_sd           = sh_q[FW-1];
  assign frame_start      = fs_q;
  assign underrun         = ur_q;
  assign smp.sample_ready = ready_q;

endmodule
